// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg: opcodes, phase encodings and instruction classes for the sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package seq_pkg;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  // Encodings double as the externally visible phase output.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    CL_R   = 3'd0,
    CL_I   = 3'd1,
    CL_LW  = 3'd2,
    CL_SW  = 3'd3,
    CL_BEQ = 3'd4,
    CL_ILL = 3'd5
  } class_e;

endpackage

`default_nettype wire

// File: rtl/op_class_decode.sv
// ---------------------------------------------------------------------------
// op_class_decode: combinational opcode to instruction class classifier
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module op_class_decode
  import seq_pkg::*;
(
  input  logic [6:0] opcode,
  output class_e     op_class,
  output logic       illegal
);

  always_comb begin
    op_class = CL_ILL;
    case (opcode)
      OP_R:    op_class = CL_R;
      OP_I:    op_class = CL_I;
      OP_LW:   op_class = CL_LW;
      OP_SW:   op_class = CL_SW;
      OP_BEQ:  op_class = CL_BEQ;
      default: op_class = CL_ILL;
    endcase
  end

  assign illegal = (op_class == CL_ILL);

endmodule

`default_nettype wire

// File: rtl/multicycle_sequencer.sv
// ---------------------------------------------------------------------------
// multicycle_sequencer: phase timing and strobes for the RV32 subset datapath
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module multicycle_sequencer
  import seq_pkg::*;
#(
  parameter int MEM_LAT    = 2,
  parameter int IO_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [6:0]  opcode,
  input  logic        io_access,
  input  logic        io_ready,
  input  logic        branch_taken,
  output logic        imem_en,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_src_branch,
  output logic        dmem_rd,
  output logic        dmem_wr,
  output logic        io_rd,
  output logic        io_wr,
  output logic        reg_we,
  output logic        instr_done,
  output logic [2:0]  phase,
  output logic        illegal_op,
  output logic        io_timeout,
  output logic [31:0] instret
);

  localparam int CNT_MAX = (MEM_LAT > IO_TIMEOUT) ? MEM_LAT : IO_TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] MEM_LAST = CW'(MEM_LAT - 1);
  localparam logic [CW-1:0] IO_LAST  = CW'(IO_TIMEOUT - 1);

  state_e          state_q, state_d;
  class_e          cls_q, cls_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            illegal_q, illegal_d;
  logic            timeout_q, timeout_d;
  logic [31:0]     instret_q, instret_d;
  logic            retire;
  class_e          dec_cls;
  logic            dec_illegal;

  op_class_decode u_op_class_decode (
    .opcode   (opcode),
    .op_class (dec_cls),
    .illegal  (dec_illegal)
  );

  always_comb begin
    state_d       = state_q;
    cls_d         = cls_q;
    illegal_d     = illegal_q;
    timeout_d     = timeout_q;
    instret_d     = instret_q;
    retire        = 1'b0;
    imem_en       = 1'b0;
    ir_we         = 1'b0;
    pc_src_branch = 1'b0;
    dmem_rd       = 1'b0;
    dmem_wr       = 1'b0;
    io_rd         = 1'b0;
    io_wr         = 1'b0;
    reg_we        = 1'b0;

    case (state_q)
      ST_IDLE: if (run) state_d = ST_FETCH;
      ST_FETCH: begin
        imem_en = 1'b1;
        if (cnt_q == MEM_LAST) begin
          ir_we   = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        cls_d = dec_cls;
        if (dec_illegal) begin
          illegal_d = 1'b1;
          state_d   = ST_TRAP;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (cls_q)
          CL_BEQ: begin
            retire        = 1'b1;
            pc_src_branch = branch_taken;
          end
          CL_LW, CL_SW: state_d = ST_MEM;
          default:      state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        // io_access is re-sampled every MEM cycle; the IO path shares cnt as its timeout.
        if (io_access) begin
          io_rd = (cls_q == CL_LW);
          io_wr = (cls_q != CL_LW);
          if (io_ready) begin
            if (cls_q == CL_LW) state_d = ST_WB;
            else                retire  = 1'b1;
          end else if (cnt_q == IO_LAST) begin
            timeout_d = 1'b1;
            state_d   = ST_TRAP;
          end
        end else if (cls_q == CL_LW) begin
          dmem_rd = 1'b1;
          if (cnt_q == MEM_LAST) state_d = ST_WB;
        end else begin
          dmem_wr = 1'b1;
          retire  = 1'b1;
        end
      end
      ST_WB: begin
        reg_we = 1'b1;
        retire = 1'b1;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_IDLE;
    endcase

    if (retire) begin
      instret_d = instret_q + 32'd1;
      state_d   = run ? ST_FETCH : ST_IDLE;
    end

    if ((state_d != state_q) || !((state_q == ST_FETCH) || (state_q == ST_MEM)))
      cnt_d = '0;
    else
      cnt_d = cnt_q + 1'b1;
  end

  assign pc_we      = retire;
  assign instr_done = retire;
  assign phase      = state_q;
  assign illegal_op = illegal_q;
  assign io_timeout = timeout_q;
  assign instret    = instret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cls_q     <= CL_R;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      instret_q <= instret_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
// ---------------------------------------------------------------------------
// tb_multicycle_sequencer: cycle-by-cycle scoreboard bench for the sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_sequencer;

  localparam int MEM_LAT    = 2;
  localparam int IO_TIMEOUT = 16;

  localparam logic [6:0] C_R   = 7'b0110011;
  localparam logic [6:0] C_I   = 7'b0010011;
  localparam logic [6:0] C_LW  = 7'b0000011;
  localparam logic [6:0] C_SW  = 7'b0100011;
  localparam logic [6:0] C_BEQ = 7'b1100011;
  localparam logic [6:0] C_JAL = 7'b1101111;

  // Strobe bits: imem ir pc_we pc_src dmem_rd dmem_wr io_rd io_wr reg_we done
  localparam logic [9:0] S_IMEM  = 10'b10_0000_0000;
  localparam logic [9:0] S_IR    = 10'b01_0000_0000;
  localparam logic [9:0] S_PCSRC = 10'b00_0100_0000;
  localparam logic [9:0] S_DRD   = 10'b00_0010_0000;
  localparam logic [9:0] S_DWR   = 10'b00_0001_0000;
  localparam logic [9:0] S_IORD  = 10'b00_0000_1000;
  localparam logic [9:0] S_IOWR  = 10'b00_0000_0100;
  localparam logic [9:0] S_REG   = 10'b00_0000_0010;
  localparam logic [9:0] S_RET   = 10'b00_1000_0001;

  logic        clk = 1'b0;
  logic        rst_n, run, io_access, io_ready, branch_taken;
  logic [6:0]  opcode;
  logic        imem_en, ir_we, pc_we, pc_src_branch, dmem_rd, dmem_wr;
  logic        io_rd, io_wr, reg_we, instr_done, illegal_op, io_timeout;
  logic [2:0]  phase;
  logic [31:0] instret;

  typedef struct packed {
    logic [6:0]  op;
    logic        acc;
    logic        bt;
    logic        run;
    logic        rdy;
    logic [14:0] exp;
  } ent_t;

  ent_t  q[$];
  int    n_chk = 0;
  int    n_fail = 0;
  int    n_ret = 0;
  int    cyc = 0;
  string tname = "reset";
  logic  m_ill = 1'b0, m_tmo = 1'b0;
  logic [6:0] d_op = 7'd0;
  logic  d_acc = 1'b0, d_bt = 1'b0, d_run = 1'b0, d_rdy = 1'b0;

  multicycle_sequencer #(.MEM_LAT(MEM_LAT), .IO_TIMEOUT(IO_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .io_access(io_access),
    .io_ready(io_ready), .branch_taken(branch_taken), .imem_en(imem_en), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src_branch(pc_src_branch), .dmem_rd(dmem_rd), .dmem_wr(dmem_wr),
    .io_rd(io_rd), .io_wr(io_wr), .reg_we(reg_we), .instr_done(instr_done),
    .phase(phase), .illegal_op(illegal_op), .io_timeout(io_timeout), .instret(instret)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] obs_vec();
    return {illegal_op, io_timeout, imem_en, ir_we, pc_we, pc_src_branch, dmem_rd,
            dmem_wr, io_rd, io_wr, reg_we, instr_done, phase};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] x);
    n_chk++;
    assert (o === x) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, x);
    end
  endtask

  task automatic push(input logic [2:0] ph, input logic [9:0] s);
    ent_t e;
    e.op  = d_op;
    e.acc = d_acc;
    e.bt  = d_bt;
    e.run = d_run;
    e.rdy = d_rdy;
    e.exp = {m_ill, m_tmo, s, ph};
    q.push_back(e);
  endtask

  task automatic push_idle();
    d_run = 1'b0;
    d_rdy = 1'b0;
    push(3'd0, 10'd0);
  endtask

  // Expected per-cycle outputs of one instruction, starting at its first FETCH cycle.
  task automatic gen_instr(input logic [6:0] op, input logic acc, input int rdy_at,
                           input logic bt, input logic r);
    logic is_lw;
    logic got;
    is_lw = (op == C_LW);
    got   = 1'b0;
    d_op = op; d_acc = acc; d_bt = bt; d_run = r; d_rdy = 1'b0;
    for (int i = 0; i < MEM_LAT; i++)
      push(3'd1, S_IMEM | ((i == MEM_LAT - 1) ? S_IR : 10'd0));
    push(3'd2, 10'd0);
    if (op == C_R || op == C_I) begin
      push(3'd3, 10'd0);
      push(3'd5, S_REG | S_RET);
    end else if (op == C_BEQ) begin
      push(3'd3, S_RET | (bt ? S_PCSRC : 10'd0));
    end else if (op == C_LW || op == C_SW) begin
      push(3'd3, 10'd0);
      if (!acc) begin
        if (is_lw) begin
          for (int i = 0; i < MEM_LAT; i++) push(3'd4, S_DRD);
          push(3'd5, S_REG | S_RET);
        end else begin
          push(3'd4, S_DWR | S_RET);
        end
      end else begin
        for (int k = 1; k <= IO_TIMEOUT && !got; k++) begin
          d_rdy = (k == rdy_at);
          if (d_rdy) begin
            got = 1'b1;
            push(3'd4, is_lw ? S_IORD : (S_IOWR | S_RET));
          end else begin
            push(3'd4, is_lw ? S_IORD : S_IOWR);
          end
        end
        d_rdy = 1'b0;
        if (got) begin
          if (is_lw) push(3'd5, S_REG | S_RET);
        end else begin
          m_tmo = 1'b1;
          repeat (3) push(3'd7, 10'd0);
        end
      end
    end else begin
      m_ill = 1'b1;
      repeat (3) push(3'd7, 10'd0);
    end
  endtask

  task automatic run_q(input int max);
    ent_t e;
    int   n;
    n = 0;
    while (q.size() > 0 && n < max) begin
      e = q.pop_front();
      @(posedge clk);
      #1;
      opcode = e.op; io_access = e.acc; branch_taken = e.bt; run = e.run; io_ready = e.rdy;
      #1;
      chk($sformatf("%s_cyc%0d_out", tname, cyc), {17'd0, obs_vec()}, {17'd0, e.exp});
      chk($sformatf("%s_cyc%0d_instret", tname, cyc), instret, 32'(n_ret));
      if (e.exp[3]) n_ret++;
      n++;
      cyc++;
    end
  endtask

  // Reset is asserted between clock edges so its effect must be asynchronous.
  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    run   = 1'b0;
    #1;
    q.delete();
    m_ill = 1'b0; m_tmo = 1'b0; n_ret = 0;
    chk({tname, "_rst_out"}, {17'd0, obs_vec()}, 32'd0);
    chk({tname, "_rst_instret"}, instret, 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; opcode = 7'd0;
    io_access = 1'b0; io_ready = 1'b0; branch_taken = 1'b0;
    #3;
    chk("reset_out", {17'd0, obs_vec()}, 32'd0);
    chk("reset_instret", instret, 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    tname = "core";
    gen_instr(C_R,   1'b0, 0, 1'b0, 1'b1);
    gen_instr(C_I,   1'b0, 0, 1'b0, 1'b1);
    gen_instr(C_LW,  1'b0, 0, 1'b0, 1'b1);
    gen_instr(C_SW,  1'b0, 0, 1'b0, 1'b1);
    gen_instr(C_BEQ, 1'b0, 0, 1'b1, 1'b1);
    gen_instr(C_BEQ, 1'b0, 0, 1'b0, 1'b0);
    push_idle();
    run = 1'b1;
    run_q(1000);

    tname = "io_lw";
    gen_instr(C_LW, 1'b1, 3, 1'b0, 1'b0);
    push_idle();
    run = 1'b1;
    run_q(1000);

    tname = "io_sw";
    gen_instr(C_SW, 1'b1, 1, 1'b0, 1'b0);
    push_idle();
    run = 1'b1;
    run_q(1000);

    tname = "io_tmo";
    gen_instr(C_LW, 1'b1, 0, 1'b0, 1'b1);
    run = 1'b1;
    run_q(1000);
    do_reset();

    tname = "illegal";
    gen_instr(C_JAL, 1'b0, 0, 1'b0, 1'b1);
    run = 1'b1;
    run_q(1000);
    do_reset();

    tname = "run_drop";
    gen_instr(C_R, 1'b0, 0, 1'b0, 1'b0);
    push_idle();
    push_idle();
    run = 1'b1;
    run_q(1000);

    // Abort a load in its first MEM cycle, after one instruction has retired.
    tname = "rst_mem";
    gen_instr(C_R,  1'b0, 0, 1'b0, 1'b1);
    gen_instr(C_LW, 1'b0, 0, 1'b0, 1'b1);
    run = 1'b1;
    run_q(2 * MEM_LAT + 6);
    do_reset();
    @(posedge clk);
    #1;
    chk("rst_mem_hold_phase", {29'd0, phase}, 32'd0);
    chk("rst_mem_hold_instret", instret, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end of test, required end before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
